// File: rtl/imem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader:
// FSM encoding, stream framing constants and the memory base address.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W         = 8;
  localparam int LEN_W          = HDR_BYTES * 8;
  localparam int WORD_W         = BYTES_PER_WORD * 8;

  localparam logic [31:0] IMEM_BASE = 32'h0000_0000;

  // Byte address of a word slot in instruction memory.
  function automatic logic [31:0] word_addr(input logic [LEN_W-1:0] idx);
    return IMEM_BASE + {{(30-LEN_W){1'b0}}, idx, 2'b00};
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: the first byte of each group of
// four lands in the least-significant lane of the word.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [1:0]        byte_cnt;
  logic [WORD_W-9:0] shift_p0;

  // The fourth byte is combined directly so the word is ready on its accept cycle.
  assign word_valid = in_valid && (byte_cnt == 2'(BYTES_PER_WORD - 1));
  assign word       = {in_byte, shift_p0};

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      byte_cnt <= 2'd0;
    end else if (in_valid) begin
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid) begin
      shift_p0 <= {in_byte, shift_p0[WORD_W-9:8]};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream into
// instruction memory writes and holds the core in reset until it verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int TIMEOUT     = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic        o_byte_ready,
  output logic        o_wr_en,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wr_data,
  output logic        o_core_rst,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [LEN_W-1:0] DEPTH_L  = LEN_W'(DEPTH_WORDS);

  state_t              state, state_nxt;
  logic [7:0]          len_lo;
  logic [LEN_W-1:0]    len;
  logic [LEN_W-1:0]    n_hdr;
  logic [LEN_W-1:0]    word_idx;
  logic [CSUM_W-1:0]   csum;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                byte_ready;
  logic                accept;
  logic                timed;
  logic                tmo_hit;
  logic                pk_in_vld;
  logic                pk_vld;
  logic [WORD_W-1:0]   pk_word;
  logic                wr_vld_p1;
  logic [31:0]         wr_addr_p1;
  logic [WORD_W-1:0]   wr_data_p1;

  assign byte_ready = (state == ST_LEN_LO) || (state == ST_LEN_HI) ||
                      (state == ST_DATA)   || (state == ST_CSUM);
  assign timed      = (state == ST_LEN_HI) || (state == ST_DATA) || (state == ST_CSUM);
  assign accept     = i_byte_valid && byte_ready;
  assign n_hdr      = {i_byte, len_lo};
  assign pk_in_vld  = accept && (state == ST_DATA);
  // An accepted byte always beats the timeout on the same cycle.
  assign tmo_hit    = timed && !accept && (tmo_cnt == TMO_LAST);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clear      (state == ST_LEN_LO),
    .in_valid   (pk_in_vld),
    .in_byte    (i_byte),
    .word_valid (pk_vld),
    .word       (pk_word)
  );

  // ST_IDLE lasts exactly one cycle so the stream is refused right after reset.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = ST_LEN_LO;
      ST_LEN_LO: if (accept) state_nxt = ST_LEN_HI;
      ST_LEN_HI: begin
        if (accept) begin
          if (n_hdr > DEPTH_L)    state_nxt = ST_ERR;
          else if (n_hdr == '0)   state_nxt = ST_CSUM;
          else                    state_nxt = ST_DATA;
        end
      end
      ST_DATA:   if (pk_vld && (word_idx == len - LEN_W'(1))) state_nxt = ST_CSUM;
      ST_CSUM:   if (accept) state_nxt = (i_byte == csum) ? ST_DONE : ST_ERR;
      ST_DONE:   state_nxt = ST_DONE;
      ST_ERR:    state_nxt = ST_ERR;
      default:   state_nxt = ST_ERR;
    endcase
    if (tmo_hit) state_nxt = ST_ERR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      len_lo   <= '0;
      len      <= '0;
      word_idx <= '0;
      csum     <= '0;
      tmo_cnt  <= '0;
    end else begin
      state <= state_nxt;
      if (timed && !accept) tmo_cnt <= tmo_cnt + TMO_W'(1);
      else                  tmo_cnt <= '0;
      if (accept && (state == ST_LEN_LO)) begin
        len_lo <= i_byte;
        csum   <= '0;
      end
      if (accept && (state == ST_LEN_HI)) len <= n_hdr;
      if (pk_in_vld) csum     <= csum ^ i_byte;
      if (pk_vld)    word_idx <= word_idx + LEN_W'(1);
    end
  end

  // Write stage: one cycle behind the fourth byte of each word.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_vld_p1  <= 1'b0;
      wr_addr_p1 <= '0;
      wr_data_p1 <= '0;
    end else begin
      wr_vld_p1 <= pk_vld;
      if (pk_vld) begin
        wr_addr_p1 <= word_addr(word_idx);
        wr_data_p1 <= pk_word;
      end
    end
  end

  assign o_byte_ready = byte_ready;
  assign o_wr_en      = wr_vld_p1;
  assign o_wr_addr    = wr_addr_p1;
  assign o_wr_data    = wr_data_p1;
  assign o_core_rst   = (state != ST_DONE);
  assign o_busy       = timed;
  assign o_done       = (state == ST_DONE);
  assign o_err        = (state == ST_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed images, expected writes queued
// at issue time and checked by an independent write monitor.
module tb_imem_loader;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] byte_d = 8'h00;
  logic       vld = 1'b0;
  logic       sel = 1'b0;

  always #5 clk = ~clk;

  logic        m_ready, m_wr_en, m_core_rst, m_busy, m_done, m_err;
  logic [31:0] m_wr_addr, m_wr_data;
  logic        t_ready, t_wr_en, t_core_rst, t_busy, t_done, t_err;
  logic [31:0] t_wr_addr, t_wr_data;

  imem_loader #(.DEPTH_WORDS(64), .TIMEOUT(1024)) u_dut (
    .clk(clk), .rst(rst), .i_byte(byte_d), .i_byte_valid(vld && !sel),
    .o_byte_ready(m_ready), .o_wr_en(m_wr_en), .o_wr_addr(m_wr_addr),
    .o_wr_data(m_wr_data), .o_core_rst(m_core_rst), .o_busy(m_busy),
    .o_done(m_done), .o_err(m_err)
  );

  imem_loader #(.DEPTH_WORDS(64), .TIMEOUT(16)) u_tmo (
    .clk(clk), .rst(rst), .i_byte(byte_d), .i_byte_valid(vld && sel),
    .o_byte_ready(t_ready), .o_wr_en(t_wr_en), .o_wr_addr(t_wr_addr),
    .o_wr_data(t_wr_data), .o_core_rst(t_core_rst), .o_busy(t_busy),
    .o_done(t_done), .o_err(t_err)
  );

  wire        ready    = sel ? t_ready    : m_ready;
  wire        wr_en    = sel ? t_wr_en    : m_wr_en;
  wire [31:0] wr_addr  = sel ? t_wr_addr  : m_wr_addr;
  wire [31:0] wr_data  = sel ? t_wr_data  : m_wr_data;
  wire        core_rst = sel ? t_core_rst : m_core_rst;
  wire        busy     = sel ? t_busy     : m_busy;
  wire        done     = sel ? t_done     : m_done;
  wire        err      = sel ? t_err      : m_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the next queued expectation.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", wr_addr, wr_data);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e[63:32]);
        check("wr_data", wr_data, e[31:0]);
      end
    end
  end

  task automatic push_w(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic send(input logic [7:0] b, input int gap, input int max_wait, output bit acc);
    acc = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    byte_d = b;
    vld    = 1'b1;
    for (int t = 0; t < max_wait; t++) begin
      if (ready) begin
        acc = 1'b1;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    vld = 1'b0;
  endtask

  task automatic put(input logic [7:0] b, input int gap);
    bit acc;
    send(b, gap, 40, acc);
    check("byte_accepted", {31'd0, acc}, 32'd1);
  endtask

  task automatic send_stream(input bq_t bs, input int gap_max);
    foreach (bs[i]) put(bs[i], (gap_max == 0) ? 0 : int'($urandom_range(0, gap_max)));
  endtask

  task automatic do_reset(input string tag);
    vld = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check({tag, "_core_rst"}, {31'd0, core_rst}, 32'd1);
    check({tag, "_ready"},    {31'd0, ready},    32'd0);
    check({tag, "_wr_en"},    {31'd0, wr_en},    32'd0);
    check({tag, "_wr_addr"},  wr_addr,           32'd0);
    check({tag, "_wr_data"},  wr_data,           32'd0);
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_done"},     {31'd0, done},     32'd0);
    check({tag, "_err"},      {31'd0, err},      32'd0);
  endtask

  task automatic check_end(input string tag, input bit exp_done);
    repeat (2) begin @(posedge clk); #1; end
    check({tag, "_done"},     {31'd0, done},     {31'd0, exp_done});
    check({tag, "_err"},      {31'd0, err},      {31'd0, !exp_done});
    check({tag, "_core_rst"}, {31'd0, core_rst}, {31'd0, !exp_done});
    check({tag, "_busy"},     {31'd0, busy},     32'd0);
    check({tag, "_pending"},  exp_q.size(),      32'd0);
    exp_q.delete();
  endtask

  // Nominal image; the XOR of its eight payload bytes is 0x21.
  task automatic nominal(input logic [7:0] cs, input int gap_max);
    bq_t bs;
    bs = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h00, 8'h01, cs};
    push_w(32'h0, 32'h00A0_0513);
    push_w(32'h4, 32'h0100_0593);
    send_stream(bs, gap_max);
  endtask

  initial begin
    bq_t bs;
    bit  acc;
    logic [7:0]  x;
    logic [31:0] w;

    do_reset("reset");

    nominal(8'h21, 0);
    check("nominal_done_next_cycle", {31'd0, done}, 32'd1);
    check("nominal_core_rst_next_cycle", {31'd0, core_rst}, 32'd0);
    check_end("nominal", 1'b1);

    // Bytes offered after DONE are refused and produce no writes.
    byte_d = 8'hFF;
    vld    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("done_ready", {31'd0, ready}, 32'd0);
      @(posedge clk); #1;
    end
    vld = 1'b0;
    check("done_sticky", {31'd0, done}, 32'd1);

    do_reset("reset2");
    nominal(8'h21, 20);
    check_end("gapped", 1'b1);

    do_reset("reset3");
    nominal(8'h36, 20);
    check_end("bad_csum", 1'b0);

    do_reset("reset4");
    bs = '{8'h41, 8'h00};
    send_stream(bs, 0);
    check("oversize_err_after_hdr", {31'd0, err}, 32'd1);
    check_end("oversize", 1'b0);

    do_reset("reset5");
    bs = '{8'h00, 8'h00, 8'h00};
    send_stream(bs, 0);
    check_end("zero_len", 1'b1);

    do_reset("reset6");
    bs = '{8'h02, 8'h00, 8'h13, 8'h05, 8'hA0};
    send_stream(bs, 0);
    check("midload_busy", {31'd0, busy}, 32'd1);
    check("midload_core_rst", {31'd0, core_rst}, 32'd1);
    do_reset("midload_rst");
    nominal(8'h21, 3);
    check_end("after_midload", 1'b1);

    // Full-depth image: word i = {i, A5, ~i, 3*i}.
    do_reset("reset7");
    bs = '{8'h40, 8'h00};
    x = 8'h00;
    for (int i = 0; i < 64; i++) begin
      w = {8'(i), 8'hA5, ~8'(i), 8'(3 * i)};
      push_w(32'(4 * i), w);
      for (int k = 0; k < 4; k++) begin
        bs.push_back(w[8*k +: 8]);
        x = x ^ w[8*k +: 8];
      end
    end
    bs.push_back(x);
    send_stream(bs, 0);
    check("full_last_addr", wr_addr, 32'h0000_00FC);
    check_end("full_depth", 1'b1);

    sel = 1'b1;
    do_reset("tmo_reset");
    bs = '{8'h02, 8'h00, 8'h13, 8'h05};
    send_stream(bs, 0);
    send(8'hA0, 16, 5, acc);
    check("tmo16_byte_refused", {31'd0, acc}, 32'd0);
    check_end("tmo16", 1'b0);

    do_reset("tmo_reset2");
    push_w(32'h0, 32'h00A0_0513);
    push_w(32'h4, 32'h0100_0593);
    bs = '{8'h02, 8'h00, 8'h13, 8'h05};
    send_stream(bs, 0);
    put(8'hA0, 15);
    bs = '{8'h00, 8'h93, 8'h05, 8'h00, 8'h01};
    send_stream(bs, 0);
    put(8'h21, 15);
    check_end("tmo15", 1'b1);
    sel = 1'b0;

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
